// File: rtl/coin_pkg.sv
// Coin acceptor shared definitions.
// FSM state encoding and coin codes seen by the vending FSM.
package coin_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_EMIT     = 3'd2,
        ST_REJECT   = 3'd3,
        ST_RELEASE  = 3'd4
    } state_t;

    localparam logic [1:0] COIN_NONE  = 2'b00;
    localparam logic [1:0] COIN_SMALL = 2'b10;
    localparam logic [1:0] COIN_LARGE = 2'b11;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one raw sensor line.
// Reset clears both stages so a held sensor reads as a fresh rise.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw input through two flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces two coin sensors, emits a coin code
// or drives the reject gate, and keeps a saturating coin count.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEB_CYCLES = 8,
    parameter int REJ_PULSE  = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sens_a,
    input  logic             sens_b,
    input  logic             accept_en,
    input  logic             cnt_clr,
    output logic [1:0]       coin_code,
    output logic             reject,
    output logic [CNT_W-1:0] coin_cnt,
    output logic             busy
);

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
    localparam logic [7:0] REJ_LAST = 8'(REJ_PULSE - 1);

    logic       sa;
    logic       sb;
    state_t     state_q;
    state_t     state_d;
    logic [7:0] dbc_q;
    logic [7:0] dbc_d;
    logic [7:0] rej_q;
    logic [7:0] rej_d;
    logic       large_q;
    logic       large_d;
    logic [1:0] code_d;
    logic       reject_d;
    logic       own;
    logic       other;

    sync_2ff u_sync_a (
        .clk (clk),
        .rst (rst),
        .d   (sens_a),
        .q   (sa)
    );

    sync_2ff u_sync_b (
        .clk (clk),
        .rst (rst),
        .d   (sens_b),
        .q   (sb)
    );

    assign own   = large_q ? sb : sa;
    assign other = large_q ? sa : sb;
    assign busy  = (state_q != ST_IDLE);

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dbc_q     <= 8'd0;
            rej_q     <= 8'd0;
            large_q   <= 1'b0;
            coin_code <= COIN_NONE;
            reject    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dbc_q     <= dbc_d;
            rej_q     <= rej_d;
            large_q   <= large_d;
            coin_code <= code_d;
            reject    <= reject_d;
        end
    end

    // Next state, counter updates and next output values.
    always_comb begin
        state_d = state_q;
        dbc_d   = dbc_q;
        rej_d   = rej_q;
        large_d = large_q;
        code_d  = COIN_NONE;
        unique case (state_q)
            ST_IDLE: begin
                if (sa && sb) begin
                    state_d = ST_REJECT;
                    rej_d   = 8'd0;
                end else if (sa || sb) begin
                    state_d = ST_DEBOUNCE;
                    large_d = sb;
                    dbc_d   = 8'd0;
                end
            end
            ST_DEBOUNCE: begin
                if (!own) begin
                    state_d = ST_IDLE;
                end else if (other) begin
                    state_d = ST_REJECT;
                    rej_d   = 8'd0;
                end else if (dbc_q == DEB_LAST) begin
                    if (accept_en) begin
                        state_d = ST_EMIT;
                        code_d  = large_q ? COIN_LARGE : COIN_SMALL;
                    end else begin
                        state_d = ST_REJECT;
                        rej_d   = 8'd0;
                    end
                end else begin
                    dbc_d = dbc_q + 8'd1;
                end
            end
            ST_EMIT: begin
                state_d = ST_RELEASE;
            end
            ST_REJECT: begin
                if (rej_q == REJ_LAST) begin
                    state_d = ST_RELEASE;
                end else begin
                    rej_d = rej_q + 8'd1;
                end
            end
            ST_RELEASE: begin
                if (!sa && !sb) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        reject_d = (state_d == ST_REJECT);
    end

    // Count coins as EMIT completes; clear wins but keeps this coin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coin_cnt <= '0;
        end else if (cnt_clr) begin
            coin_cnt <= (state_q == ST_EMIT) ? CNT_W'(1) : '0;
        end else if (state_q == ST_EMIT && coin_cnt != '1) begin
            coin_cnt <= coin_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor (DEB_CYCLES=8, REJ_PULSE=4,
// CNT_W=2): coin scenario table plus reset and clear sequences.
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst;
    logic       sens_a;
    logic       sens_b;
    logic       accept_en;
    logic       cnt_clr;
    logic [1:0] coin_code;
    logic       reject;
    logic [1:0] coin_cnt;
    logic       busy;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       a;
        logic       b;
        int         hold;
        logic       acc_s;
        logic       acc_o;
        int         e_ncode;
        int         e_code;
        int         e_nrej;
        int         e_cnt;
    } vec_t;

    vec_t tbl[11];

    always #5 clk = ~clk;

    coin_acceptor #(
        .DEB_CYCLES (8),
        .REJ_PULSE  (4),
        .CNT_W      (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sens_a    (sens_a),
        .sens_b    (sens_b),
        .accept_en (accept_en),
        .cnt_clr   (cnt_clr),
        .coin_code (coin_code),
        .reject    (reject),
        .coin_cnt  (coin_cnt),
        .busy      (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one coin starting at a negedge; edge 0 is the next posedge.
    // accept_en takes acc_s only for edge 10 (the sampling edge).
    task automatic run_coin(
        input  logic a,
        input  logic b,
        input  int   hold,
        input  logic acc_s,
        input  logic acc_o,
        input  logic clr_on_emit,
        output int   ncode,
        output int   code,
        output int   code_edge,
        output int   nrej,
        output int   rej_runs,
        output int   gaps,
        output int   timeout
    );
        logic prev_rej;
        ncode     = 0;
        code      = 0;
        code_edge = -1;
        nrej      = 0;
        rej_runs  = 0;
        gaps      = 0;
        timeout   = 1;
        prev_rej  = 1'b0;
        sens_a    = a && (hold > 0);
        sens_b    = b && (hold > 0);
        accept_en = acc_o;
        cnt_clr   = 1'b0;
        for (int k = 0; k < hold + 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (coin_code != 2'b00) begin
                ncode++;
                code = int'(coin_code);
                if (code_edge < 0) code_edge = k;
            end
            if (reject) begin
                nrej++;
                if (!prev_rej) rej_runs++;
            end
            prev_rej = reject;
            if (k >= 2 && k < hold && !busy) gaps++;
            if (k >= hold + 2 && !busy) begin
                timeout = 0;
                break;
            end
            sens_a    = a && (k + 1 < hold);
            sens_b    = b && (k + 1 < hold);
            accept_en = (k + 1 == 10) ? acc_s : acc_o;
            cnt_clr   = clr_on_emit && (coin_code != 2'b00);
        end
        sens_a  = 1'b0;
        sens_b  = 1'b0;
        cnt_clr = 1'b0;
    endtask

    initial begin
        int nc, cd, ce, nr, rr, gp, to;

        //           a     b     hold acc_s acc_o nc code nrej cnt
        tbl[0]  = '{1'b1, 1'b0, 20, 1'b1, 1'b1, 1, 2, 0, 1};
        tbl[1]  = '{1'b0, 1'b1, 4,  1'b1, 1'b1, 0, 0, 0, 1};
        tbl[2]  = '{1'b0, 1'b1, 20, 1'b0, 1'b0, 0, 0, 4, 1};
        tbl[3]  = '{1'b1, 1'b1, 20, 1'b1, 1'b1, 0, 0, 4, 1};
        tbl[4]  = '{1'b0, 1'b1, 20, 1'b1, 1'b0, 1, 3, 0, 2};
        tbl[5]  = '{1'b1, 1'b0, 2,  1'b1, 1'b1, 0, 0, 0, 2};
        tbl[6]  = '{1'b0, 1'b1, 20, 1'b0, 1'b1, 0, 0, 4, 2};
        tbl[7]  = '{1'b1, 1'b0, 8,  1'b1, 1'b1, 0, 0, 0, 2};
        tbl[8]  = '{1'b1, 1'b0, 9,  1'b1, 1'b1, 1, 2, 0, 3};
        tbl[9]  = '{1'b0, 1'b1, 20, 1'b1, 1'b1, 1, 3, 0, 3};
        tbl[10] = '{1'b0, 1'b1, 20, 1'b1, 1'b1, 1, 3, 0, 3};

        rst       = 1'b1;
        sens_a    = 1'b0;
        sens_b    = 1'b0;
        accept_en = 1'b0;
        cnt_clr   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_code", int'(coin_code), 0);
        check("rst_reject", int'(reject), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cnt", int'(coin_cnt), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_coin(tbl[i].a, tbl[i].b, tbl[i].hold,
                     tbl[i].acc_s, tbl[i].acc_o, 1'b0,
                     nc, cd, ce, nr, rr, gp, to);
            check($sformatf("v%0d_ncode", i), nc, tbl[i].e_ncode);
            if (tbl[i].e_ncode > 0) begin
                check($sformatf("v%0d_code", i), cd, tbl[i].e_code);
                check($sformatf("v%0d_code_edge", i), ce, 10);
            end
            check($sformatf("v%0d_nrej", i), nr, tbl[i].e_nrej);
            if (tbl[i].e_nrej > 0)
                check($sformatf("v%0d_rej_runs", i), rr, 1);
            check($sformatf("v%0d_busy_gap", i), gp, 0);
            check($sformatf("v%0d_timeout", i), to, 0);
            check($sformatf("v%0d_cnt", i), int'(coin_cnt), tbl[i].e_cnt);
        end

        // Clear landing on the EMIT cycle keeps the new coin.
        run_coin(1'b0, 1'b1, 20, 1'b1, 1'b1, 1'b1,
                 nc, cd, ce, nr, rr, gp, to);
        check("clr_emit_ncode", nc, 1);
        check("clr_emit_timeout", to, 0);
        check("clr_emit_cnt", int'(coin_cnt), 1);

        cnt_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cnt_clr = 1'b0;
        check("clr_cnt", int'(coin_cnt), 0);

        // Reset at debounce count 5, sensor kept high across it.
        sens_a    = 1'b1;
        accept_en = 1'b1;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("mid_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_code", int'(coin_code), 0);
        check("mid_rst_reject", int'(reject), 0);
        @(negedge clk);
        check("mid_rst_cnt", int'(coin_cnt), 0);
        rst = 1'b0;
        run_coin(1'b1, 1'b0, 12, 1'b1, 1'b1, 1'b0,
                 nc, cd, ce, nr, rr, gp, to);
        check("rerun_ncode", nc, 1);
        check("rerun_code", cd, 2);
        check("rerun_code_edge", ce, 10);
        check("rerun_nrej", nr, 0);
        check("rerun_timeout", to, 0);
        check("rerun_cnt", int'(coin_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
